// File: rtl/vmm_pkg.sv
// Shared types and defaults for the sequential vector x matrix MAC (vec_mat_mac_seq).
package vmm_pkg;

    // Job sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vmm_state_e;

    localparam int VMM_DATA_W = 20;
    localparam int VMM_ACC_W  = 40;
    localparam int VMM_ROWS   = 4;
    localparam int VMM_COLS   = 4;

    // Row counter width: enough to index ROWS rows, never narrower than one bit.
    function automatic int vmm_cnt_w(input int rows);
        if (rows > 1) begin
            return $clog2(rows);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/vmm_mac_lane.sv
// One multiply-accumulate lane of vec_mat_mac_seq.
// Build option: VMM_SATURATE_EN clamps the accumulator to all-ones on overflow;
// without it the accumulator wraps. The sticky overflow flag behaves the same in both.
module vmm_mac_lane
    import vmm_pkg::*;
#(
    parameter int DATA_W = VMM_DATA_W,
    parameter int ACC_W  = VMM_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    logic [2*DATA_W-1:0] prod_s;
    logic [ACC_W:0]      sum_s;
    logic [ACC_W-1:0]    acc_r;
    logic                ovf_r;

    // Product zero-extended to the accumulator width plus one carry bit.
    always_comb begin
        prod_s = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
        sum_s  = {1'b0, acc_r} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, prod_s};
    end

    // Accumulator and sticky overflow; cleared at job start, updated only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
        end else if (en) begin
`ifdef VMM_SATURATE_EN
            // Once clamped, stay clamped until the next job start.
            if (ovf_r || sum_s[ACC_W]) begin
                acc_r <= {ACC_W{1'b1}};
            end else begin
                acc_r <= sum_s[ACC_W-1:0];
            end
`else
            acc_r <= sum_s[ACC_W-1:0];
`endif
            ovf_r <= ovf_r | sum_s[ACC_W];
        end
    end

    assign acc = acc_r;
    assign ovf = ovf_r;

endmodule

// File: rtl/vec_mat_mac_seq.sv
// Sequential vector x matrix multiply: vals[j] = sum_k a[k]*b[k][j].
// COLS lanes consume one matrix row per clock; results and overflow flags are held between jobs.
// Build option: VMM_SATURATE_EN (saturating lanes instead of wrapping lanes).
module vec_mat_mac_seq
    import vmm_pkg::*;
#(
    parameter int DATA_W = VMM_DATA_W,
    parameter int ACC_W  = VMM_ACC_W,
    parameter int ROWS   = VMM_ROWS,
    parameter int COLS   = VMM_COLS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic                                      ready,
    input  logic [ROWS-1:0][DATA_W-1:0]               a,
    input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]     b,
    output logic                                      busy,
    output logic                                      done,
    output logic [COLS-1:0][ACC_W-1:0]                vals,
    output logic [COLS-1:0]                           ovf
);

    localparam int CNT_W = vmm_cnt_w(ROWS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    generate
        if (ACC_W < 2*DATA_W) begin : g_bad_acc_w
            $error("vec_mat_mac_seq: ACC_W must be at least 2*DATA_W");
        end
        if (ROWS < 1 || COLS < 1) begin : g_bad_dims
            $error("vec_mat_mac_seq: ROWS and COLS must be at least 1");
        end
    endgenerate

    vmm_state_e state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic accept_s;
    logic run_s;

    logic [ROWS-1:0][DATA_W-1:0]           a_r;
    logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] b_r;

    logic [COLS-1:0][ACC_W-1:0] lane_acc_s;
    logic [COLS-1:0]            lane_ovf_s;

    logic [COLS-1:0][ACC_W-1:0] vals_r;
    logic [COLS-1:0]            ovf_r;
    logic                       ready_r;
    logic                       busy_r;
    logic                       done_r;

    // Next-state and row-counter logic; start is only honoured in IDLE.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        accept_s = 1'b0;
        run_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n  = RUN;
                    cnt_n    = {CNT_W{1'b0}};
                    accept_s = 1'b1;
                end else begin
                    state_n  = IDLE;
                end
            end
            RUN: begin
                run_s = 1'b1;
                if (cnt_r == LAST_ROW) begin
                    state_n = DONE;
                    cnt_n   = {CNT_W{1'b0}};
                end else begin
                    state_n = RUN;
                    cnt_n   = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, handshake flags and result registers; results move only out of DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            vals_r  <= {(COLS*ACC_W){1'b0}};
            ovf_r   <= {COLS{1'b0}};
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            ready_r <= (state_n == IDLE);
            busy_r  <= (state_n == RUN);
            done_r  <= (state_r == DONE);
            if (state_r == DONE) begin
                vals_r <= lane_acc_s;
                ovf_r  <= lane_ovf_s;
            end
        end
    end

    // Operand capture on an accepted start, so a/b may change during the job.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= {(ROWS*DATA_W){1'b0}};
            b_r <= {(ROWS*COLS*DATA_W){1'b0}};
        end else if (accept_s) begin
            a_r <= a;
            b_r <= b;
        end
    end

    generate
        for (genvar j = 0; j < COLS; j++) begin : g_lane
            vmm_mac_lane #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk (clk),
                .rst (rst),
                .clr (accept_s),
                .en  (run_s),
                .x   (a_r[cnt_r]),
                .y   (b_r[cnt_r][j]),
                .acc (lane_acc_s[j]),
                .ovf (lane_ovf_s[j])
            );
        end
    endgenerate

    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign vals  = vals_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_vec_mat_mac_seq.sv
// Self-checking bench for vec_mat_mac_seq against an arithmetic reference model.
module tb_vec_mat_mac_seq;
    import vmm_pkg::*;

    localparam int DATA_W = 20;
    localparam int ACC_W  = 40;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;

    typedef logic [ROWS-1:0][DATA_W-1:0]           vec_t;
    typedef logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] mat_t;
    typedef logic [COLS-1:0][ACC_W-1:0]            res_t;

    logic clk;
    logic rst;
    logic start;
    logic ready;
    logic busy;
    logic done;
    vec_t a;
    mat_t b;
    res_t vals;
    logic [COLS-1:0] ovf;

    int   n_vec = 0;
    int   n_err = 0;
    res_t last_exp;
    logic [COLS-1:0] last_ovf;

    vec_mat_mac_seq #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .ROWS   (ROWS),
        .COLS   (COLS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .vals  (vals),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact sum in a wide integer; overflow means the true sum does not fit in ACC_W bits.
    task automatic model(input vec_t ma, input mat_t mb, output res_t ev, output logic [COLS-1:0] eo);
        for (int j = 0; j < COLS; j++) begin
            logic [ACC_W+7:0] tot;
            tot = '0;
            for (int k = 0; k < ROWS; k++) begin
                tot = tot + ((ACC_W+8)'(ma[k]) * (ACC_W+8)'(mb[k][j]));
            end
            eo[j] = ((tot >> ACC_W) != '0);
`ifdef VMM_SATURATE_EN
            ev[j] = eo[j] ? {ACC_W{1'b1}} : tot[ACC_W-1:0];
`else
            ev[j] = tot[ACC_W-1:0];
`endif
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < ROWS; k++) begin
            a[k] = DATA_W'($urandom);
            for (int j = 0; j < COLS; j++) begin
                b[k][j] = DATA_W'($urandom);
            end
        end
    endtask

    task automatic check_res(input string tag, input res_t ev, input logic [COLS-1:0] eo);
        for (int j = 0; j < COLS; j++) begin
            check_eq($sformatf("%s_val%0d", tag, j), 64'(vals[j]), 64'(ev[j]));
        end
        check_eq({tag, "_ovf"}, 64'(ovf), 64'(eo));
    endtask

    // One job from IDLE; optionally pulses start during RUN, which must be ignored.
    task automatic run_job(input string tag, input bit poke);
        res_t ev;
        logic [COLS-1:0] eo;
        int lat;
        model(a, b, ev, eo);
        check_eq({tag, "_ready"}, 64'(ready), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rand_ops();
        check_eq({tag, "_busy"}, 64'(busy), 64'd1);
        check_eq({tag, "_notready"}, 64'(ready), 64'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            start = (poke && lat == 2) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check_eq({tag, "_lat"}, 64'(lat), 64'(ROWS + 1));
        check_res(tag, ev, eo);
        for (int c = 0; c < 2*ROWS + 4; c++) begin
            @(posedge clk); #1;
            check_eq({tag, "_nodone"}, 64'(done), 64'd0);
        end
        check_res({tag, "_held"}, ev, eo);
        last_exp = ev;
        last_ovf = eo;
    endtask

    res_t            q_v[$];
    logic [COLS-1:0] q_o[$];
    int              cyc;
    int              last_done;
    int              ndone;

    task automatic b2b_cycle();
        res_t ev;
        logic [COLS-1:0] eo;
        @(posedge clk); #1;
        cyc++;
        if (done === 1'b1) begin
            if (q_v.size() == 0) begin
                check_eq("b2b_spurious", 64'd1, 64'd0);
            end else begin
                ev = q_v.pop_front();
                eo = q_o.pop_front();
                check_res("b2b", ev, eo);
                if (last_done >= 0) begin
                    check_eq("b2b_spacing", 64'(cyc - last_done), 64'(ROWS + 2));
                end
                last_done = cyc;
                last_exp  = ev;
                last_ovf  = eo;
                ndone++;
            end
        end else begin
            check_res("b2b_hold", last_exp, last_ovf);
        end
    endtask

    initial begin
        res_t ev;
        logic [COLS-1:0] eo;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_res("reset", '0, '0);
        check_eq("reset_ready", 64'(ready), 64'd1);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity matrix.
        for (int k = 0; k < ROWS; k++) a[k] = DATA_W'(k + 1);
        b = '0;
        for (int k = 0; k < ROWS; k++) b[k][k] = DATA_W'(1);
        run_job("ident", 1'b0);
        check_eq("ident_v3_const", 64'(vals[3]), 64'd4);

        // b[k][j] = k+j+1 with an ignored start pulse during RUN.
        for (int k = 0; k < ROWS; k++) begin
            a[k] = DATA_W'(k + 1);
            for (int j = 0; j < COLS; j++) b[k][j] = DATA_W'(k + j + 1);
        end
        run_job("ramp", 1'b1);
        check_eq("ramp_v0_const", 64'(vals[0]), 64'd30);
        check_eq("ramp_v3_const", 64'(vals[3]), 64'd60);

        // All operands at maximum: every lane overflows.
        a = '1;
        b = '1;
        run_job("maxov", 1'b0);
        check_eq("maxov_ovf_const", 64'(ovf), 64'hF);

        // Random jobs, some with small operands so both overflow and clean cases occur.
        for (int t = 0; t < 8; t++) begin
            rand_ops();
            if (t % 2 == 1) begin
                for (int k = 0; k < ROWS; k++) begin
                    a[k] = a[k] >> 4;
                    for (int j = 0; j < COLS; j++) b[k][j] = b[k][j] >> 4;
                end
            end
            run_job($sformatf("rnd%0d", t), t[0] & t[1]);
        end

        // Reset during the third RUN cycle aborts the job.
        rand_ops();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_ready", 64'(ready), 64'd1);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_res("abort", '0, '0);
        for (int c = 0; c < ROWS + 4; c++) begin
            @(posedge clk); #1;
            check_eq("abort_nodone", 64'(done), 64'd0);
        end
        check_res("abort_held", '0, '0);
        rand_ops();
        run_job("after_abort", 1'b0);

        // Back-to-back with start held high.
        cyc       = 0;
        last_done = -1;
        ndone     = 0;
        start     = 1'b1;
        rand_ops();
        for (int c = 0; c < 40; c++) begin
            if (ready === 1'b1) begin
                model(a, b, ev, eo);
                q_v.push_back(ev);
                q_o.push_back(eo);
            end
            b2b_cycle();
            rand_ops();
        end
        start = 1'b0;
        for (int c = 0; c < 3*(ROWS + 2) && q_v.size() != 0; c++) begin
            b2b_cycle();
        end
        check_eq("b2b_drain", 64'(q_v.size()), 64'd0);
        check_eq("b2b_jobs", 64'(ndone >= 6), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
